// File: rtl/ka_mult_seq.sv
// Sequential one-level Karatsuba carry-less multiplier over GF(2)[x] with optional
// reduction modulo x^W + POLY; the three half-products share one digit-serial core.
module ka_mult_seq #(
  parameter int unsigned  W     = 163,
  parameter int unsigned  DIGIT = 8,
  parameter logic [W-1:0] POLY  = 'hC9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           reduce,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-2:0] y
);
  localparam int unsigned H  = (W + 1) / 2;
  localparam int unsigned NC = (H + DIGIT - 1) / DIGIT;
  localparam int unsigned YP = NC * DIGIT;
  localparam int unsigned PW = 2 * H - 1;
  localparam int unsigned YW = 2 * W - 1;
  localparam int unsigned CW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [2:0] {
    StIdle, StMulLo, StMulHi, StMulMid, StCombine, StReduce, StDone
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_q, b_q;
  logic          red_q;
  logic [PW-1:0] acc_q, p_lo_q, p_hi_q, p_mid_q;
  logic [YW-1:0] full_q;

  logic [H-1:0]     a_lo, a_hi, b_lo, b_hi, x_op, y_op;
  logic [YP-1:0]    y_pad;
  logic [DIGIT-1:0] digs [NC];
  logic [DIGIT-1:0] digit;
  logic [PW-1:0]    prod, acc_d, mid_x;
  logic [YW-1:0]    full_d, rem, red_y;

  // Operand selection and one MSB-first digit step of the shared core.
  always_comb begin
    a_lo = a_q[H-1:0];
    a_hi = H'(a_q[W-1:H]);
    b_lo = b_q[H-1:0];
    b_hi = H'(b_q[W-1:H]);
    case (state_q)
      StMulHi: begin
        x_op = a_hi;
        y_op = b_hi;
      end
      StMulMid: begin
        x_op = a_lo ^ a_hi;
        y_op = b_lo ^ b_hi;
      end
      default: begin
        x_op = a_lo;
        y_op = b_lo;
      end
    endcase
    y_pad = YP'(y_op);
    for (int k = 0; k < int'(NC); k++) begin
      digs[k] = y_pad[(int'(NC) - 1 - k) * int'(DIGIT) +: DIGIT];
    end
    digit = digs[cnt_q];
    prod  = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (digit[i]) prod = prod ^ (PW'(x_op) << i);
    end
    acc_d = (acc_q << DIGIT) ^ prod;
  end

  // Karatsuba recombination and top-down fold using x^W == POLY.
  always_comb begin
    mid_x  = p_lo_q ^ p_hi_q ^ p_mid_q;
    full_d = YW'(p_lo_q) ^ (YW'(mid_x) << H) ^ (YW'(p_hi_q) << (2 * H));
    rem    = full_q;
    for (int i = int'(YW) - 1; i >= int'(W); i--) begin
      if (rem[i]) begin
        rem[i] = 1'b0;
        rem    = rem ^ (YW'(POLY) << (i - int'(W)));
      end
    end
    red_y = red_q ? rem : full_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      red_q     <= 1'b0;
      acc_q     <= '0;
      p_lo_q    <= '0;
      p_hi_q    <= '0;
      p_mid_q   <= '0;
      full_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            red_q    <= reduce;
            acc_q    <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StMulLo;
          end
        end
        StMulLo, StMulHi, StMulMid: begin
          if (cnt_q == CW'(NC - 1)) begin
            cnt_q <= '0;
            acc_q <= '0;
            if (state_q == StMulLo) begin
              p_lo_q  <= acc_d;
              state_q <= StMulHi;
            end else if (state_q == StMulHi) begin
              p_hi_q  <= acc_d;
              state_q <= StMulMid;
            end else begin
              p_mid_q <= acc_d;
              state_q <= StCombine;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
            acc_q <= acc_d;
          end
        end
        StCombine: begin
          full_q  <= full_d;
          state_q <= StReduce;
        end
        StReduce: begin
          y         <= red_y;
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ka_mult_seq.sv
// Scoreboard bench for ka_mult_seq: a default (W=163) and a small (W=41, DIGIT=4)
// instance, checked against a schoolbook carry-less multiply and polynomial remainder.
module tb_ka_mult_seq;
  localparam int unsigned BW = 163;
  localparam int unsigned SW = 41;
  localparam int unsigned MW = 2 * BW - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          big_in_valid = 1'b0, big_in_ready, big_reduce = 1'b0;
  logic          big_out_valid, big_out_ready = 1'b0;
  logic [BW-1:0] big_a = '0, big_b = '0;
  logic [MW-1:0] big_y;

  logic            sml_in_valid = 1'b0, sml_in_ready, sml_reduce = 1'b0;
  logic            sml_out_valid, sml_out_ready = 1'b0;
  logic [SW-1:0]   sml_a = '0, sml_b = '0;
  logic [2*SW-2:0] sml_y;

  ka_mult_seq u_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (big_in_valid),
    .in_ready  (big_in_ready),
    .a         (big_a),
    .b         (big_b),
    .reduce    (big_reduce),
    .out_valid (big_out_valid),
    .out_ready (big_out_ready),
    .y         (big_y)
  );

  ka_mult_seq #(
    .W     (SW),
    .DIGIT (4),
    .POLY  (41'h9)
  ) u_sml (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (sml_in_valid),
    .in_ready  (sml_in_ready),
    .a         (sml_a),
    .b         (sml_b),
    .reduce    (sml_reduce),
    .out_valid (sml_out_valid),
    .out_ready (sml_out_ready),
    .y         (sml_y)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [MW-1:0] q_big[$];
  logic [MW-1:0] q_sml[$];

  function automatic logic [MW-1:0] clmul(input logic [MW-1:0] x, input logic [MW-1:0] z,
                                          input int w);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < w; i++) if (z[i]) r = r ^ (x << i);
    return r;
  endfunction

  function automatic logic [MW-1:0] gf_mod(input logic [MW-1:0] v, input int w,
                                           input logic [MW-1:0] poly);
    logic [MW-1:0] r, p_full;
    r      = v;
    p_full = poly | (MW'(1) << w);
    for (int i = 2 * w - 2; i >= w; i--) if (r[i]) r = r ^ (p_full << (i - w));
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_valid(input bit sel);
    return sel ? sml_out_valid : big_out_valid;
  endfunction

  function automatic logic cur_ready(input bit sel);
    return sel ? sml_in_ready : big_in_ready;
  endfunction

  function automatic logic [MW-1:0] cur_y(input bit sel);
    return sel ? MW'(sml_y) : big_y;
  endfunction

  task automatic set_in(input bit sel, input logic v, input logic [MW-1:0] av,
                        input logic [MW-1:0] bv, input logic rv);
    if (sel) begin
      sml_in_valid = v;
      sml_a        = av[SW-1:0];
      sml_b        = bv[SW-1:0];
      sml_reduce   = rv;
    end else begin
      big_in_valid = v;
      big_a        = av[BW-1:0];
      big_b        = bv[BW-1:0];
      big_reduce   = rv;
    end
  endtask

  task automatic set_oready(input bit sel, input logic v);
    if (sel) sml_out_ready = v;
    else big_out_ready = v;
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic start_op(input bit sel, input logic [MW-1:0] av, input logic [MW-1:0] bv,
                          input logic rv, input logic [MW-1:0] exp);
    string tg;
    tg = sel ? "sml" : "big";
    set_in(sel, 1'b1, av, bv, rv);
    check_eq({tg, "_accept_ready"}, MW'(cur_ready(sel)), MW'(1));
    @(posedge clk);
    if (sel) q_sml.push_back(exp);
    else q_big.push_back(exp);
    @(negedge clk);
    set_in(sel, 1'b0, ~av, ~bv, ~rv);
  endtask

  task automatic finish_op(input bit sel, input int exp_lat, input int hold);
    int            lat;
    bit            busy_rdy;
    logic [MW-1:0] exp_y;
    string         tg;
    tg       = sel ? "sml" : "big";
    lat      = 0;
    busy_rdy = 1'b0;
    exp_y    = '0;
    while (!cur_valid(sel) && lat < 300) begin
      busy_rdy |= cur_ready(sel);
      @(negedge clk);
      lat++;
    end
    if (exp_lat != 0) check_eq({tg, "_latency"}, MW'(lat), MW'(exp_lat));
    check_eq({tg, "_busy_in_ready"}, MW'(busy_rdy), MW'(0));
    check_eq({tg, "_sb_depth"}, MW'(sel ? q_sml.size() : q_big.size()), MW'(1));
    if (sel && q_sml.size() > 0) exp_y = q_sml.pop_front();
    if (!sel && q_big.size() > 0) exp_y = q_big.pop_front();
    check_eq({tg, "_y"}, cur_y(sel), exp_y);
    for (int k = 0; k < hold; k++) begin
      set_in(sel, k[0], MW'({$urandom, $urandom}), MW'({$urandom, $urandom}), 1'b0);
      @(negedge clk);
      check_eq({tg, "_hold_y"}, cur_y(sel), exp_y);
      check_eq({tg, "_hold_valid"}, MW'(cur_valid(sel)), MW'(1));
    end
    set_in(sel, 1'b0, '0, '0, 1'b0);
    set_oready(sel, 1'b1);
    @(negedge clk);
    set_oready(sel, 1'b0);
    check_eq({tg, "_post_valid"}, MW'(cur_valid(sel)), MW'(0));
    check_eq({tg, "_post_ready"}, MW'(cur_ready(sel)), MW'(1));
    check_eq({tg, "_post_y_held"}, cur_y(sel), exp_y);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] p, x162, av, bv, mask;
    logic          rv;
    p    = MW'('hC9);
    x162 = MW'(1) << 162;
    mask = (MW'(1) << SW) - MW'(1);

    repeat (3) @(negedge clk);
    check_eq("rst_big_in_ready", MW'(big_in_ready), MW'(1));
    check_eq("rst_big_out_valid", MW'(big_out_valid), MW'(0));
    check_eq("rst_big_y", big_y, MW'(0));
    check_eq("rst_sml_y", MW'(sml_y), MW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    start_op(0, MW'(1), MW'(1), 1'b0, MW'(1));
    finish_op(0, 35, 0);
    start_op(0, x162, x162, 1'b0, MW'(1) << 324);
    finish_op(0, 35, 0);
    start_op(0, x162, x162, 1'b1, gf_mod(MW'(1) << 324, BW, p));
    finish_op(0, 35, 0);
    start_op(0, x162, MW'(2), 1'b1, MW'('hC9));
    finish_op(0, 35, 0);
    start_op(0, x162, MW'(2), 1'b0, MW'(1) << 163);
    finish_op(0, 35, 0);

    // Back-pressure with ignored in_valid pulses, then an immediate follow-up op.
    av = MW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}) & ((MW'(1) << BW) - 1);
    bv = MW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}) & ((MW'(1) << BW) - 1);
    start_op(0, av, bv, 1'b1, gf_mod(clmul(av, bv, BW), BW, p));
    finish_op(0, 35, 7);
    start_op(0, bv, av ^ bv, 1'b0, clmul(bv, av ^ bv, BW));
    finish_op(0, 35, 0);

    // Reset while MUL_HI is running discards the operation.
    start_op(0, av, bv, 1'b0, clmul(av, bv, BW));
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_out_valid", MW'(big_out_valid), MW'(0));
    check_eq("midrst_y", big_y, MW'(0));
    check_eq("midrst_in_ready", MW'(big_in_ready), MW'(1));
    q_big.delete();
    start_op(0, av, bv, 1'b1, gf_mod(clmul(av, bv, BW), BW, p));
    finish_op(0, 35, 0);

    start_op(1, mask, MW'(1), 1'b0, mask);
    finish_op(1, 20, 0);
    for (int n = 0; n < 1000; n++) begin
      av = MW'({$urandom, $urandom}) & mask;
      bv = MW'({$urandom, $urandom}) & mask;
      rv = 1'($urandom_range(0, 1));
      start_op(1, av, bv, rv, rv ? gf_mod(clmul(av, bv, SW), SW, MW'(9)) : clmul(av, bv, SW));
      finish_op(1, 20, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
